// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared widths, stop/max speeds, default timing and ramp helper for the servo controller
package servo_pkg;

  localparam int SPEED_W    = 8;
  localparam int STEP_W     = 3;
  localparam int SPEED_STOP = 128;
  localparam int SPEED_MAX  = 255;

  // Defaults assume a 50 MHz clock: 20 ms frame, 1 ms minimum pulse, ~2 ms at full speed
  localparam int FRAME_CYC_DEF = 1_000_000;
  localparam int MIN_CYC_DEF   = 50_000;
  localparam int LSB_CYC_DEF   = 195;

  localparam int PULSE_W = 32;

  typedef logic [SPEED_W-1:0] speed_t;
  typedef logic [STEP_W-1:0]  step_t;

  function automatic speed_t sat_add(input speed_t speed, input step_t step);
    logic [SPEED_W:0] sum;
    sum = {1'b0, speed} + {{(SPEED_W + 1 - STEP_W){1'b0}}, step};
    return sum[SPEED_W] ? speed_t'(SPEED_MAX) : sum[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/servo_control_if.sv
// rtl/servo_control_if.sv - per-wheel speed/step request bundle and PWM outputs between drive-mode logic and servo_control
interface servo_control_if;
  import servo_pkg::*;

  logic   servo_0_speed_write_en;
  logic   servo_1_speed_write_en;
  speed_t servo_0_speed;
  speed_t servo_1_speed;
  step_t  servo_0_step;
  step_t  servo_1_step;
  logic   PWM_OUT_0;
  logic   PWM_OUT_1;

  modport master (
    output servo_0_speed_write_en, servo_1_speed_write_en,
    output servo_0_speed, servo_1_speed,
    output servo_0_step, servo_1_step,
    input  PWM_OUT_0, PWM_OUT_1
  );

  modport slave (
    input  servo_0_speed_write_en, servo_1_speed_write_en,
    input  servo_0_speed, servo_1_speed,
    input  servo_0_step, servo_1_step,
    output PWM_OUT_0, PWM_OUT_1
  );

endinterface

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: speed register, saturating ramp, frame latch and registered PWM compare
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int MIN_CYC   = MIN_CYC_DEF,
  parameter int LSB_CYC   = LSB_CYC_DEF,
  parameter int SPEED_RST = SPEED_STOP,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_end,
  input  logic [CNT_W-1:0] cnt,
  input  logic             write_en,
  input  speed_t           speed_in,
  input  step_t            step,
  output logic             pwm
);

  speed_t             speed_q;
  speed_t             latched_q;
  logic [PULSE_W-1:0] pulse_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q <= speed_t'(SPEED_RST);
    end else if (write_en) begin
      speed_q <= speed_in;
    end else if (frame_end) begin
      speed_q <= sat_add(speed_q, step);
    end
  end

  // Pulse width only moves at frame boundaries so a mid-frame write never truncates a pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched_q <= speed_t'(SPEED_RST);
    end else if (frame_end) begin
      latched_q <= speed_q;
    end
  end

  assign pulse_len = PULSE_W'(MIN_CYC) + PULSE_W'(latched_q) * PULSE_W'(LSB_CYC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (PULSE_W'(cnt) < pulse_len);
    end
  end

endmodule

// File: rtl/servo_control.sv
// rtl/servo_control.sv - two-channel continuous-rotation servo PWM controller sharing one frame counter
module servo_control
  import servo_pkg::*;
#(
  parameter int FRAME_CYC = FRAME_CYC_DEF,
  parameter int MIN_CYC   = MIN_CYC_DEF,
  parameter int LSB_CYC   = LSB_CYC_DEF,
  parameter int SPEED_RST = SPEED_STOP
) (
  input  logic            clk,
  input  logic            rst,
  servo_control_if.slave  bus
);

  localparam int CNT_W = $clog2(FRAME_CYC);

  logic [CNT_W-1:0] cnt;
  logic             frame_end;

  assign frame_end = (cnt == CNT_W'(FRAME_CYC - 1));

  // Single counter keeps both channel frames phase-aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (frame_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  servo_pwm_channel #(
    .MIN_CYC   (MIN_CYC),
    .LSB_CYC   (LSB_CYC),
    .SPEED_RST (SPEED_RST),
    .CNT_W     (CNT_W)
  ) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end),
    .cnt       (cnt),
    .write_en  (bus.servo_0_speed_write_en),
    .speed_in  (bus.servo_0_speed),
    .step      (bus.servo_0_step),
    .pwm       (bus.PWM_OUT_0)
  );

  servo_pwm_channel #(
    .MIN_CYC   (MIN_CYC),
    .LSB_CYC   (LSB_CYC),
    .SPEED_RST (SPEED_RST),
    .CNT_W     (CNT_W)
  ) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end),
    .cnt       (cnt),
    .write_en  (bus.servo_1_speed_write_en),
    .speed_in  (bus.servo_1_speed),
    .step      (bus.servo_1_step),
    .pwm       (bus.PWM_OUT_1)
  );

endmodule

// File: tb/tb_servo_control.sv
// tb/tb_servo_control.sv - scoreboard bench: expected pulse widths queued per frame, monitor measures and compares
module tb_servo_control;
  import servo_pkg::*;

  localparam int FRAME = 1000;
  localparam int MIN   = 100;
  localparam int LSB   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  servo_control_if bus();

  servo_control #(
    .FRAME_CYC (FRAME),
    .MIN_CYC   (MIN),
    .LSB_CYC   (LSB),
    .SPEED_RST (128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q0[$];
  int exp_q1[$];
  int edges;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  int hi_cnt[2];
  bit was_hi[2];

  always @(negedge clk) begin
    logic [1:0] pwm;
    int         exp_w;
    bit         have;
    pwm = {bus.PWM_OUT_1, bus.PWM_OUT_0};
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        hi_cnt[ch] = 0;
        was_hi[ch] = 0;
      end else if (pwm[ch]) begin
        if (!was_hi[ch])
          check($sformatf("align_ch%0d_f%0d", ch, edges / FRAME), edges % FRAME, 1);
        hi_cnt[ch]++;
        was_hi[ch] = 1;
      end else if (was_hi[ch]) begin
        exp_w = 0;
        if (ch == 0) begin
          have = exp_q0.size() > 0;
          if (have) exp_w = exp_q0.pop_front();
        end else begin
          have = exp_q1.size() > 0;
          if (have) exp_w = exp_q1.pop_front();
        end
        if (!have) begin
          n_total++;
          $display("FAIL width_ch%0d_f%0d: got pulse of %0d cycles, expected none", ch, edges / FRAME, hi_cnt[ch]);
        end else begin
          check($sformatf("width_ch%0d_f%0d", ch, edges / FRAME), hi_cnt[ch], exp_w);
        end
        hi_cnt[ch] = 0;
        was_hi[ch] = 0;
      end
    end
  end

  task automatic wait_edges(input int n);
    int guard;
    guard = 0;
    while (edges != n) begin
      @(negedge clk);
      guard++;
      if (guard > 100000) begin
        $display("FAIL wait_edges: got edge %0d, expected %0d", edges, n);
        $fatal(1, "edge wait expired");
      end
    end
  endtask

  task automatic push_frame(input int f, input int e0, input int e1);
    wait_edges(FRAME * f);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
  endtask

  task automatic write_ch(input int f, input int ch, input int spd);
    wait_edges(FRAME * f + 500);
    if (ch == 0) begin
      bus.servo_0_speed_write_en = 1'b1;
      bus.servo_0_speed          = speed_t'(spd);
    end else begin
      bus.servo_1_speed_write_en = 1'b1;
      bus.servo_1_speed          = speed_t'(spd);
    end
    @(negedge clk);
    bus.servo_0_speed_write_en = 1'b0;
    bus.servo_1_speed_write_en = 1'b0;
  endtask

  initial begin
    int s0;
    bus.servo_0_speed_write_en = 1'b0;
    bus.servo_1_speed_write_en = 1'b0;
    bus.servo_0_speed          = '0;
    bus.servo_1_speed          = '0;
    bus.servo_0_step           = '0;
    bus.servo_1_step           = '0;

    @(negedge clk);
    check("rst_pwm0", bus.PWM_OUT_0, 0);
    check("rst_pwm1", bus.PWM_OUT_1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle at stop speed, then load ch0 full forward, ch1 full reverse
    push_frame(0, 228, 228);
    push_frame(1, 228, 228);
    write_ch(1, 0, 255);
    push_frame(2, 355, 228);
    write_ch(2, 1, 0);
    push_frame(3, 355, 100);

    // Ramp ch0 from 250 by 3 into saturation
    write_ch(3, 0, 250);
    bus.servo_0_step = 3'd3;
    push_frame(4, 350, 100);
    push_frame(5, 353, 100);
    push_frame(6, 355, 100);
    push_frame(7, 355, 100);

    // Both channels back to stop, then ramp by 7 and 1 per frame
    wait_edges(FRAME * 7 + 500);
    bus.servo_0_step           = 3'd0;
    bus.servo_0_speed_write_en = 1'b1;
    bus.servo_1_speed_write_en = 1'b1;
    bus.servo_0_speed          = 8'd128;
    bus.servo_1_speed          = 8'd128;
    @(negedge clk);
    bus.servo_0_speed_write_en = 1'b0;
    bus.servo_1_speed_write_en = 1'b0;
    bus.servo_0_step           = 3'd7;
    bus.servo_1_step           = 3'd1;
    for (int k = 0; k <= 20; k++) begin
      s0 = 128 + 7 * k;
      if (s0 > 255) s0 = 255;
      push_frame(8 + k, MIN + s0, 228 + k);
    end

    // Reset in the middle of frame 29's pulses
    wait_edges(FRAME * 29 + 50);
    check("pre_rst_pwm0", bus.PWM_OUT_0, 1);
    check("pre_rst_pwm1", bus.PWM_OUT_1, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm0", bus.PWM_OUT_0, 0);
    check("async_rst_pwm1", bus.PWM_OUT_1, 0);
    bus.servo_0_step = '0;
    bus.servo_1_step = '0;
    repeat (3) @(negedge clk);
    check("held_rst_pwm0", bus.PWM_OUT_0, 0);
    check("held_rst_pwm1", bus.PWM_OUT_1, 0);
    rst = 1'b0;

    push_frame(0, 228, 228);
    push_frame(1, 228, 228);
    wait_edges(FRAME * 2 + 10);
    check("leftover_q0", exp_q0.size(), 0);
    check("leftover_q1", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
